// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces two raw coin sensors, detects
// jammed sensors, arbitrates ambiguous insertions and buffers up to two coin
// codes for vending_machine, emitting each as a one-cycle code on coin.
// Build option: define COIN_CREDIT_COUNT_EN to add credit_clear/credit_total.

module coin_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sens_sync,
    output logic detect,
    output logic busy,
    output logic jammed,
    output logic jam_next
);
    localparam int CW = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    // The IDLE sample that starts RISE is the first of the stable samples,
    // so RISE itself needs DEBOUNCE_CYCLES-1 more highs.
    localparam logic [CW-1:0] RISE_LAST = CW'(DEBOUNCE_CYCLES - 2);
    localparam logic [CW-1:0] LOW_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] JAM_LAST  = CW'(JAM_CYCLES - 1);
    localparam logic [CW-1:0] JAM_MAX   = CW'(JAM_CYCLES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RISE = 3'd1,
        HIGH = 3'd2,
        FALL = 3'd3,
        JAM  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] hi_cnt_r, hi_cnt_s;
    logic [CW-1:0] lo_cnt_r, lo_cnt_s;
    logic          detect_s;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            hi_cnt_r <= CNT_ZERO;
            lo_cnt_r <= CNT_ZERO;
        end else begin
            state_r  <= state_s;
            hi_cnt_r <= hi_cnt_s;
            lo_cnt_r <= lo_cnt_s;
        end
    end

    // Next-state, counter update and detect event.
    always_comb begin
        state_s  = state_r;
        hi_cnt_s = hi_cnt_r;
        lo_cnt_s = lo_cnt_r;
        detect_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sens_sync) begin
                    state_s  = RISE;
                    hi_cnt_s = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            RISE: begin
                if (!sens_sync) begin
                    state_s  = IDLE;
                    hi_cnt_s = CNT_ZERO;
                end else if (hi_cnt_r >= RISE_LAST) begin
                    detect_s = 1'b1;
                    state_s  = HIGH;
                    hi_cnt_s = CNT_ZERO;
                end else begin
                    hi_cnt_s = hi_cnt_r + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sens_sync) begin
                    state_s  = FALL;
                    lo_cnt_s = CNT_ONE;
                end else if (hi_cnt_r >= JAM_LAST) begin
                    state_s  = JAM;
                    hi_cnt_s = JAM_MAX;
                    lo_cnt_s = CNT_ZERO;
                end else begin
                    hi_cnt_s = hi_cnt_r + CNT_ONE;
                end
            end
            FALL: begin
                if (sens_sync) begin
                    state_s  = HIGH;
                    lo_cnt_s = CNT_ZERO;
                end else if (lo_cnt_r >= LOW_LAST) begin
                    state_s  = IDLE;
                    hi_cnt_s = CNT_ZERO;
                    lo_cnt_s = CNT_ZERO;
                end else begin
                    lo_cnt_s = lo_cnt_r + CNT_ONE;
                end
            end
            JAM: begin
                if (sens_sync) begin
                    lo_cnt_s = CNT_ZERO;
                end else if (lo_cnt_r >= LOW_LAST) begin
                    state_s  = IDLE;
                    hi_cnt_s = CNT_ZERO;
                    lo_cnt_s = CNT_ZERO;
                end else begin
                    lo_cnt_s = lo_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s  = IDLE;
                hi_cnt_s = CNT_ZERO;
                lo_cnt_s = CNT_ZERO;
            end
        endcase
    end

    assign detect   = detect_s;
    assign busy     = (state_r == RISE) || (state_r == HIGH);
    assign jammed   = (state_r == JAM);
    assign jam_next = (state_s == JAM);
endmodule

module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 16,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens5,
    input  logic       sens10,
    input  logic       coin_ready,
    output logic [1:0] coin,
    output logic       coin_reject,
    output logic       jam,
    output logic       fifo_full
`ifdef COIN_CREDIT_COUNT_EN
    ,
    input  logic        credit_clear,
    output logic [15:0] credit_total
`endif
);
    localparam logic [1:0] FULL_OCC = 2'(FIFO_DEPTH);

    logic [1:0] sync5_r, sync10_r;
    logic       det5_s, det10_s, busy5_s, busy10_s;
    logic       jammed5_s, jammed10_s, jam_next5_s, jam_next10_s;
    logic       any_det_s, conflict_s, pop_s, accept_s, reject_s;
    logic [1:0] code_s, head_s;
    logic [1:0] slot0_r, slot1_r, slot0_s, slot1_s;
    logic [1:0] occ_r, occ_s;
    logic [1:0] coin_r;
    logic       coin_reject_r, jam_r, fifo_full_r;

    // Two-flop synchronisers for the asynchronous sensor lines.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync5_r  <= 2'b00;
            sync10_r <= 2'b00;
        end else begin
            sync5_r  <= {sync5_r[0], sens5};
            sync10_r <= {sync10_r[0], sens10};
        end
    end

    coin_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_ch5 (
        .clk(clk), .reset(reset), .sens_sync(sync5_r[1]),
        .detect(det5_s), .busy(busy5_s), .jammed(jammed5_s), .jam_next(jam_next5_s)
    );

    coin_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_ch10 (
        .clk(clk), .reset(reset), .sens_sync(sync10_r[1]),
        .detect(det10_s), .busy(busy10_s), .jammed(jammed10_s), .jam_next(jam_next10_s)
    );

    // Arbitration: ambiguous or jammed insertions are returned; a pop in the
    // same cycle frees a slot for an otherwise-full buffer. A pop is only
    // taken when coin was idle last cycle so codes are separated by a zero.
    always_comb begin
        any_det_s  = det5_s | det10_s;
        conflict_s = (det5_s & det10_s) | (det5_s & busy10_s) | (det10_s & busy5_s)
                   | jammed5_s | jammed10_s;
        pop_s      = (occ_r != 2'd0) && coin_ready && (coin_r == 2'b00);
        accept_s   = any_det_s && !conflict_s && ((occ_r != FULL_OCC) || pop_s);
        reject_s   = any_det_s && !accept_s;
        code_s     = det5_s ? 2'b01 : 2'b10;
        head_s     = pop_s ? slot0_r : 2'b00;
    end

    // Buffer update: slot0 is the head; pop shifts slot1 forward.
    always_comb begin
        slot0_s = slot0_r;
        slot1_s = slot1_r;
        occ_s   = occ_r;
        case ({pop_s, accept_s})
            2'b10: begin
                slot0_s = slot1_r;
                slot1_s = 2'b00;
                occ_s   = occ_r - 2'd1;
            end
            2'b01: begin
                if (occ_r == 2'd0) begin
                    slot0_s = code_s;
                end else begin
                    slot1_s = code_s;
                end
                occ_s = occ_r + 2'd1;
            end
            2'b11: begin
                if (occ_r == 2'd1) begin
                    slot0_s = code_s;
                    slot1_s = 2'b00;
                end else begin
                    slot0_s = slot1_r;
                    slot1_s = code_s;
                end
                occ_s = occ_r;
            end
            default: begin
                occ_s = occ_r;
            end
        endcase
    end

    // Buffer storage and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot0_r       <= 2'b00;
            slot1_r       <= 2'b00;
            occ_r         <= 2'd0;
            coin_r        <= 2'b00;
            coin_reject_r <= 1'b0;
            jam_r         <= 1'b0;
            fifo_full_r   <= 1'b0;
        end else begin
            slot0_r       <= slot0_s;
            slot1_r       <= slot1_s;
            occ_r         <= occ_s;
            coin_r        <= head_s;
            coin_reject_r <= reject_s;
            jam_r         <= jam_next5_s | jam_next10_s;
            fifo_full_r   <= (occ_s == FULL_OCC);
        end
    end

    assign coin        = coin_r;
    assign coin_reject = coin_reject_r;
    assign jam         = jam_r;
    assign fifo_full   = fifo_full_r;

`ifdef COIN_CREDIT_COUNT_EN
    logic [15:0] credit_r;
    logic [16:0] credit_sum_s;

    // Credit adds the value of the coin being emitted this cycle.
    always_comb begin
        if (pop_s) begin
            credit_sum_s = {1'b0, credit_r} + ((slot0_r == 2'b01) ? 17'd5 : 17'd10);
        end else begin
            credit_sum_s = {1'b0, credit_r};
        end
    end

    // Saturating credit register; clear takes priority over an add.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credit_r <= 16'd0;
        end else if (credit_clear) begin
            credit_r <= 16'd0;
        end else if (credit_sum_s[16]) begin
            credit_r <= 16'hFFFF;
        end else begin
            credit_r <= credit_sum_s[15:0];
        end
    end

    assign credit_total = credit_r;
`endif
endmodule
